// File: rtl/mem_sweep_checker.sv
// mem_sweep_checker: BIST sequencer that fills a dual-port BRAM with a seeded pattern, reads it back and reports mismatches
module mem_sweep_checker #(
    parameter int WID_MEM   = 1,
    parameter int DEPTH_MEM = 128,
    parameter int ADDR_W    = 7,
    parameter int ERR_W     = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [ADDR_W-1:0]  seed,
    output logic [ADDR_W-1:0]  waddr,
    output logic [WID_MEM-1:0] din,
    output logic [ADDR_W-1:0]  raddr,
    input  logic [WID_MEM-1:0] dout,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [ERR_W-1:0]   err_count,
    output logic [ADDR_W-1:0]  first_err_addr
);
    typedef enum logic [2:0] {IDLE, FILL, VERIFY, DRAIN, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH_MEM - 1);

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  cnt_q, cnt_d, seed_q, seed_d, first_q, first_d;
    logic [ADDR_W-1:0]  waddr_q, waddr_d, raddr_q, raddr_d, cmp_addr;
    logic [WID_MEM-1:0] din_q, din_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic               busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic               go, cmp, miss;

    function automatic logic [WID_MEM-1:0] pat(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] s);
        logic [WID_MEM-1:0] p;
        p = '0;
        for (int i = 0; i < WID_MEM; i++) p[i] = a[i % ADDR_W] ^ s[i % ADDR_W];
        return p;
    endfunction

    // Sequencing, compare/score logic, and next values of the registered memory-side outputs
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        seed_d   = seed_q;
        err_d    = err_q;
        first_d  = first_q;
        go       = start && (state_q == IDLE || state_q == DONE);
        cmp      = (state_q == VERIFY && cnt_q != '0) || state_q == DRAIN;
        cmp_addr = cnt_q - 1'b1;
        miss     = cmp && (dout != pat(cmp_addr, seed_q));
        if (go) begin
            state_d = FILL;
            cnt_d   = '0;
            seed_d  = seed;
            err_d   = '0;
            first_d = '0;
        end else begin
            case (state_q)
                FILL: begin
                    state_d = (cnt_q == LAST) ? VERIFY : FILL;
                    cnt_d   = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
                end
                VERIFY: begin
                    state_d = (cnt_q == LAST) ? DRAIN : VERIFY;
                    cnt_d   = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
                end
                DRAIN:   state_d = DONE;
                default: state_d = state_q;
            endcase
            if (miss) begin
                err_d   = (err_q == '1) ? err_q : err_q + 1'b1;
                first_d = (err_q == '0) ? cmp_addr : first_q;
            end
        end
        waddr_d = (state_d == FILL) ? cnt_d :
                  (state_d == VERIFY || state_d == DRAIN) ? cnt_d - 1'b1 : '0;
        din_d   = (state_d == IDLE) ? '0 : pat(waddr_d, seed_d);
        raddr_d = (state_d == VERIFY) ? cnt_d : '0;
        busy_d  = state_d == FILL || state_d == VERIFY || state_d == DRAIN;
        done_d  = state_d == DONE;
        pass_d  = done_d && err_d == '0;
    end

    // State and registered outputs; reset drops any partial result
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            seed_q  <= '0;
            err_q   <= '0;
            first_q <= '0;
            waddr_q <= '0;
            din_q   <= '0;
            raddr_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            seed_q  <= seed_d;
            err_q   <= err_d;
            first_q <= first_d;
            waddr_q <= waddr_d;
            din_q   <= din_d;
            raddr_q <= raddr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign waddr          = waddr_q;
    assign din            = din_q;
    assign raddr          = raddr_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = err_q;
    assign first_err_addr = first_q;
endmodule

// File: tb/tb_mem_sweep_checker.sv
// tb_mem_sweep_checker: directed vector bench with BRAM models for mem_sweep_checker
module tb_mem_sweep_checker;
    localparam int D = 128;

    typedef struct {
        logic [6:0] seed;
        logic [7:0] fa;
        logic [7:0] fb;
        logic       inv;
        int         err;
        int         first;
        logic       pass;
    } vec_t;

    logic       clk = 1'b0, reset = 1'b1, start = 1'b0, start2 = 1'b0;
    logic [6:0] seed = '0;
    logic [6:0] waddr, raddr, first, waddr2, raddr2, first2;
    logic       din, dout, busy, done, pass, din2, dout2, busy2, done2, pass2;
    logic [7:0] err;
    logic [1:0] err2;
    logic [7:0] fa = 8'hFF, fb = 8'hFF;
    logic       inv = 1'b0;
    logic       mem1 [D];
    logic       mem2 [D];
    logic       mq1, mq2;
    logic [6:0] lra1;
    int         n_chk = 0, n_fail = 0;
    vec_t       vecs [5];

    always #5 clk = ~clk;

    mem_sweep_checker dut (
        .clk(clk), .reset(reset), .start(start), .seed(seed),
        .waddr(waddr), .din(din), .raddr(raddr), .dout(dout),
        .busy(busy), .done(done), .pass(pass),
        .err_count(err), .first_err_addr(first)
    );

    mem_sweep_checker #(.ERR_W(2)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .seed(seed),
        .waddr(waddr2), .din(din2), .raddr(raddr2), .dout(dout2),
        .busy(busy2), .done(done2), .pass(pass2),
        .err_count(err2), .first_err_addr(first2)
    );

    // Read-first BRAMs with registered output, writing every clock
    always @(posedge clk) begin
        mq1 <= mem1[raddr];
        mem1[waddr] <= din;
        lra1 <= raddr;
        mq2 <= mem2[raddr2];
        mem2[waddr2] <= din2;
    end

    assign dout  = mq1 ^ (inv | ({1'b0, lra1} == fa) | ({1'b0, lra1} == fb));
    assign dout2 = ~mq2;

    function automatic logic pat(input logic [6:0] a, input logic [6:0] s);
        return a[0] ^ s[0];
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_waddr"}, waddr, 0);
        chk({nm, "_din"}, din, 0);
        chk({nm, "_raddr"}, raddr, 0);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_done"}, done, 0);
        chk({nm, "_pass"}, pass, 0);
        chk({nm, "_err"}, err, 0);
        chk({nm, "_first"}, first, 0);
    endtask

    task automatic launch(input logic [6:0] s, input logic keep);
        @(negedge clk);
        seed  = s;
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!keep) start = 1'b0;
        chk("busy_rise", busy, 1);
    endtask

    task automatic follow(input logic [6:0] s, output int n);
        int r;
        n = 0;
        while (!done && n < 400) begin
            if (n < D) begin
                chk("fill_waddr", waddr, n);
                chk("fill_din", din, pat(7'(n), s));
                chk("fill_raddr", raddr, 0);
            end else if (n < 2 * D) begin
                r = n - D;
                chk("verify_raddr", raddr, r);
                chk("verify_waddr", waddr, (r + D - 1) % D);
                chk("verify_din", din, pat(7'((r + D - 1) % D), s));
            end else begin
                chk("drain_waddr", waddr, D - 1);
                chk("drain_din", din, pat(7'(D - 1), s));
                chk("drain_raddr", raddr, 0);
            end
            chk("busy_during_run", busy, 1);
            @(posedge clk);
            #1;
            n++;
        end
        chk("done_latency", n, 2 * D + 1);
        chk("busy_fall", busy, 0);
    endtask

    initial begin
        int n;
        vecs[0] = '{7'h00, 8'hFF, 8'hFF, 1'b0, 0, 0, 1'b1};
        vecs[1] = '{7'h2A, 8'd5, 8'd9, 1'b0, 2, 5, 1'b0};
        vecs[2] = '{7'h13, 8'd127, 8'hFF, 1'b0, 1, 127, 1'b0};
        vecs[3] = '{7'h7F, 8'd0, 8'hFF, 1'b0, 1, 0, 1'b0};
        vecs[4] = '{7'h55, 8'hFF, 8'hFF, 1'b1, 128, 0, 1'b0};

        #2 reset = 1'b0;
        #1 chk_zero("in_reset");
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1 chk_zero("idle");
        end

        for (int i = 0; i < 5; i++) begin
            fa  = vecs[i].fa;
            fb  = vecs[i].fb;
            inv = vecs[i].inv;
            launch(vecs[i].seed, 1'b0);
            follow(vecs[i].seed, n);
            chk("vec_done", done, 1);
            chk("vec_pass", pass, vecs[i].pass);
            chk("vec_err", err, vecs[i].err);
            chk("vec_first", first, vecs[i].first);
            @(posedge clk);
            #1;
            chk("scrub_waddr", waddr, 0);
            chk("scrub_din", din, pat(7'd0, vecs[i].seed));
            chk("scrub_raddr", raddr, 0);
            chk("done_hold", done, 1);
            chk("err_hold", err, vecs[i].err);
        end

        fa  = 8'd5;
        fb  = 8'd9;
        inv = 1'b0;
        launch(7'h2A, 1'b1);
        follow(7'h2A, n);
        chk("held_err", err, 2);
        chk("held_first", first, 5);
        fa = 8'hFF;
        fb = 8'hFF;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("restart_done", done, 0);
        chk("restart_pass", pass, 0);
        chk("restart_busy", busy, 1);
        chk("restart_err", err, 0);
        chk("restart_first", first, 0);
        follow(7'h2A, n);
        chk("restart_final_pass", pass, 1);
        chk("restart_final_err", err, 0);

        launch(7'h11, 1'b0);
        repeat (D + 40) @(posedge clk);
        #1 chk("mid_raddr", raddr, 40);
        chk("mid_busy", busy, 1);
        #1 reset = 1'b0;
        #1 chk_zero("async_reset");
        repeat (2) @(posedge clk);
        #1 chk_zero("held_reset");
        @(negedge clk) reset = 1'b1;
        launch(7'h11, 1'b0);
        follow(7'h11, n);
        chk("after_reset_pass", pass, 1);
        chk("after_reset_err", err, 0);

        @(negedge clk) start2 = 1'b1;
        @(posedge clk);
        #1 start2 = 1'b0;
        n = 0;
        while (!done2 && n < 400) begin
            @(posedge clk);
            #1 n++;
        end
        chk("sat_latency", n, 2 * D + 1);
        chk("sat_err", err2, 3);
        chk("sat_first", first2, 0);
        chk("sat_pass", pass2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_sweep_checker.md
# mem_sweep_checker

Built-in self-test sequencer for the simple dual-port block-RAM test memory: drives its `waddr`/`din`/`raddr` and consumes its registered `dout`. On `start` it fills every address with a seed-derived pattern, reads every address back, compares each returned word, and reports pass/fail, a saturating error count and the first failing address. Instantiated beside the memory in the BRAM test tops so that patched bitstreams can be checked in hardware.

## Interface

Parameters:

- `WID_MEM`, default 1: memory word width.
- `DEPTH_MEM`, default 128: number of words; power of two.
- `ADDR_W`, default 7: address width; `2**ADDR_W == DEPTH_MEM`.
- `ERR_W`, default 8: error counter width.

Ports:

- `clk`  in  1: single clock, shared with the memory.
- `reset`  in  1: reset. One clock; reset is asynchronous and active-low.
- `start`  in  1: level-sampled each cycle; begins a run when in IDLE or DONE.
- `seed`  in  ADDR_W: pattern seed, latched on the accepted `start`.
- `waddr`  out  ADDR_W: write address to the memory.
- `din`  out  WID_MEM: write data to the memory.
- `raddr`  out  ADDR_W: read address to the memory.
- `dout`  in  WID_MEM: memory read data, valid one cycle after `raddr`.
- `busy`  out  1: high in FILL, VERIFY and DRAIN.
- `done`  out  1: high in DONE.
- `pass`  out  1: in DONE, high iff `err_count == 0`; 0 otherwise.
- `err_count`  out  ERR_W: mismatch count, saturates at all-ones.
- `first_err_addr`  out  ADDR_W: address of the first mismatch of the run; 0 if none.

## Operation

- Pattern: `P(a)` bit i = bit (i mod ADDR_W) of (`a` XOR `seed_q`). `seed_q` holds its value until the next accepted `start`.
- The memory writes on every clock and has no write enable. The checker therefore always drives a defined `waddr`/`din` pair.
- All outputs are registered. Reset value of every output is 0, and the state resets to IDLE.
- States:
  - IDLE:
    - `waddr`=0, `din`=0, `raddr`=0.
    - `start` → FILL, latch `seed`, clear `err_count` and `first_err_addr`.
  - FILL:
    - Write counter a = 0..DEPTH_MEM-1, one per cycle: `waddr`=a, `din`=P(a).
    - `raddr` is held at 0.
    - After a = DEPTH_MEM-1 → VERIFY.
  - VERIFY:
    - Read counter r = 0..DEPTH_MEM-1: `raddr`=r.
    - Scrub write: `waddr`=r-1, `din`=P(r-1), starting at r=1. For r=0 the write repeats address DEPTH_MEM-1 with P(DEPTH_MEM-1).
    - Each cycle from r=1 onward, `dout` is compared with P(r-1).
    - After r = DEPTH_MEM-1 → DRAIN.
  - DRAIN (1 cycle):
    - Compare `dout` with P(DEPTH_MEM-1).
    - Write `waddr`=DEPTH_MEM-1, `din`=P(DEPTH_MEM-1).
    - → DONE.
  - DONE:
    - `done`=1, `pass` valid.
    - Scrub continues: `raddr`=0, `waddr`=0, `din`=P(0).
    - `start` → FILL (new run, counters cleared).
- On a mismatch:
  - `err_count` increments, saturating at 2^ERR_W-1.
  - On the first mismatch of a run, `first_err_addr` captures the compared address.
- `start` in FILL, VERIFY or DRAIN is ignored.
- Reset asserted mid-run: immediate return to IDLE with all outputs at 0. No partial result is retained.
- The counters wrap only via state exit. They never wrap silently inside a state.

## Timing

- E0 is the edge that samples `start`=1 in IDLE or DONE.
- FILL occupies the cycles after edges E0..E(D-1), where D = DEPTH_MEM.
- VERIFY occupies the cycles after edges ED..E(2D-1).
- DRAIN occupies the cycle after edge E2D.
- `done`=1 and `pass` are valid from edge E(2D+1): 2·DEPTH_MEM+1 edges after the sampling edge.
- `busy` rises at E0 and falls at E(2D+1), on the same edge that `done` rises.
- `err_count` and `first_err_addr` update on the edge that ends the compare cycle. The final values are stable when `done` rises.
- Read-first memory: in VERIFY, the read of r occurs at least one edge before the scrub write of r.
- A restart from DONE drops `done`/`pass` and clears the counters at E0.

## Test plan

- Reset, idle, no start:
  - All outputs stay 0; `waddr`=0, `din`=0 every cycle.
- Clean run with D=128, `seed`=0:
  - `done` rises 257 edges after `start`.
  - `pass`=1, `err_count`=0, `first_err_addr`=0.
  - During FILL, `din` equals `waddr[0]`.
- Bench flips `dout` on the compare of addresses 5 and 9 with `seed`=7'h2A:
  - `err_count`=2, `first_err_addr`=5, `pass`=0.
- ERR_W=2, bench inverts every `dout` word:
  - `err_count` saturates at 3, `first_err_addr`=0, `pass`=0.
- `start` held high through the whole run, then again in DONE:
  - No restart during busy.
  - Restart at DONE: counters cleared, second `done` 257 edges later.
- `reset` asserted at VERIFY r=40, then released and `start` pulsed:
  - Outputs go to 0 immediately.
  - The new run completes with `pass`=1.
